// File: rtl/inst_pkg.sv
// Shared definitions for the instruction loader: address width default, instruction
// field bit positions, word width and the loader state encoding.
package inst_pkg;

    localparam int unsigned P_ADDR_DEF = 8;

    // Instruction word layout, MSB first: {imm, exw, exr, a, b, jt}
    function automatic int unsigned word_w(input int unsigned p);
        return 3 + 3 * p;
    endfunction

    function automatic int unsigned imm_pos(input int unsigned p);
        return 3 * p + 2;
    endfunction

    function automatic int unsigned exw_pos(input int unsigned p);
        return 3 * p + 1;
    endfunction

    function automatic int unsigned exr_pos(input int unsigned p);
        return 3 * p;
    endfunction

    function automatic int unsigned a_lsb(input int unsigned p);
        return 2 * p;
    endfunction

    function automatic int unsigned b_lsb(input int unsigned p);
        return p;
    endfunction

    function automatic int unsigned jt_lsb(input int unsigned p);
        return 0 * p;
    endfunction

    localparam int unsigned W_DEF = word_w(P_ADDR_DEF);

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_WRITE = 2'd2,
        LD_DONE  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/inst_pack.sv
// Combinational instruction packer; the exact inverse of the decoder field map.
module inst_pack
    import inst_pkg::*;
#(
    parameter int unsigned P_ADDR = P_ADDR_DEF
) (
    input  logic                        imm,
    input  logic                        exw,
    input  logic                        exr,
    input  logic [P_ADDR-1:0]           a,
    input  logic [P_ADDR-1:0]           b,
    input  logic [P_ADDR-1:0]           jt,
    output logic [word_w(P_ADDR)-1:0]   word
);

    localparam int unsigned IMM_B = imm_pos(P_ADDR);
    localparam int unsigned EXW_B = exw_pos(P_ADDR);
    localparam int unsigned EXR_B = exr_pos(P_ADDR);
    localparam int unsigned A_L   = a_lsb(P_ADDR);
    localparam int unsigned B_L   = b_lsb(P_ADDR);
    localparam int unsigned JT_L  = jt_lsb(P_ADDR);

    always_comb begin
        word                  = '0;
        word[IMM_B]           = imm;
        word[EXW_B]           = exw;
        word[EXR_B]           = exr;
        word[A_L  +: P_ADDR]  = a;
        word[B_L  +: P_ADDR]  = b;
        word[JT_L +: P_ADDR]  = jt;
    end

endmodule

// File: rtl/inst_loader.sv
// Program loader: accepts instruction field tuples and writes packed words to
// consecutive instruction-memory addresses starting at 0 after each start pulse.
module inst_loader
    import inst_pkg::*;
#(
    parameter int unsigned P_ADDR = P_ADDR_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        imm,
    input  logic                        exw,
    input  logic                        exr,
    input  logic [P_ADDR-1:0]           a,
    input  logic [P_ADDR-1:0]           b,
    input  logic [P_ADDR-1:0]           jt,
    input  logic                        last,
    output logic                        mem_we,
    output logic [P_ADDR-1:0]           mem_addr,
    output logic [word_w(P_ADDR)-1:0]   mem_wdata,
    output logic                        busy,
    output logic                        done,
    output logic                        ovf,
    output logic [P_ADDR:0]             count
);

    localparam int unsigned W = word_w(P_ADDR);

    ld_state_e          state_q, state_d;
    logic [P_ADDR-1:0]  addr_q, addr_d;
    logic [P_ADDR-1:0]  maddr_q, maddr_d;
    logic [W-1:0]       wdata_q, wdata_d;
    logic               last_q, last_d;
    logic [P_ADDR:0]    count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [W-1:0]       packed_word;
    logic               accept;
    logic               at_top;

    inst_pack #(
        .P_ADDR (P_ADDR)
    ) u_pack (
        .imm  (imm),
        .exw  (exw),
        .exr  (exr),
        .a    (a),
        .b    (b),
        .jt   (jt),
        .word (packed_word)
    );

    assign accept = in_valid & in_ready;
    assign at_top = (addr_q == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = LD_LOAD;
        end else begin
            case (state_q)
                LD_LOAD:  if (accept) state_d = LD_WRITE;
                LD_WRITE: state_d = (last_q || at_top) ? LD_DONE : LD_LOAD;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        in_ready = (state_q == LD_LOAD) && !start;
        mem_we   = (state_q == LD_WRITE);
        busy     = (state_q == LD_LOAD) || (state_q == LD_WRITE);
        done     = (state_q == LD_DONE);
        mem_addr = maddr_q;
        mem_wdata = wdata_q;
        ovf      = ovf_q;
        count    = count_q;
    end

    // start overrides the WRITE bookkeeping; mem_we of that cycle is still issued
    always_comb begin
        addr_d  = addr_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (start) begin
            addr_d  = '0;
            maddr_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            maddr_d = addr_q;
            wdata_d = packed_word;
            last_d  = last;
        end else if (state_q == LD_WRITE) begin
            count_d = count_q + (P_ADDR+1)'(1);
            if (at_top) begin
                ovf_d = !last_q;
            end else if (!last_q) begin
                addr_d = addr_q + P_ADDR'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            maddr_q <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader at P_ADDR=4: directed scenarios plus
// randomized programs checked against an arithmetic reference model.
module tb_inst_loader;

    localparam int P = 4;
    localparam int W = 3 + 3 * P;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         imm = 1'b0, exw = 1'b0, exr = 1'b0, last = 1'b0;
    logic [P-1:0] a = '0, b = '0, jt = '0;
    logic         mem_we;
    logic [P-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         busy, done, ovf;
    logic [P:0]   count;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int exp_addr  = 0;
    int exp_count = 0;
    bit exp_ovf   = 0;
    bit exp_done  = 0;
    int last_word = 0;
    int sent      = 0;

    inst_loader #(.P_ADDR(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .exw       (exw),
        .exr       (exr),
        .a         (a),
        .b         (b),
        .jt        (jt),
        .last      (last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pack_ref(input int i_imm, i_exw, i_exr, i_a, i_b, i_jt);
        return i_imm * (1 << (3*P+2)) + i_exw * (1 << (3*P+1)) + i_exr * (1 << (3*P))
             + i_a * (1 << (2*P)) + i_b * (1 << P) + i_jt;
    endfunction

    // decoder model: pull a field of given width out of the word by arithmetic
    function automatic int dec(input int w, input int lsb, input int width);
        return (w / (1 << lsb)) % (1 << width);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_addr  = 0;
        exp_count = 0;
        exp_ovf   = 0;
        exp_done  = 0;
        #1;
        chk("ready_after_start", in_ready, 1);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic send(input int i_imm, i_exw, i_exr, i_a, i_b, i_jt, input int i_last, input int gap);
        int budget;
        int exp_word;
        int w;
        repeat (gap) step();
        imm = i_imm[0]; exw = i_exw[0]; exr = i_exr[0];
        a = i_a[P-1:0]; b = i_b[P-1:0]; jt = i_jt[P-1:0];
        last = i_last[0];
        in_valid = 1'b1;
        budget = 8;
        #1;
        while (!in_ready && budget > 0) begin
            step();
            budget--;
        end
        chk("ready_wait", (budget > 0), 1);
        step();
        in_valid = 1'b0;
        exp_word = pack_ref(i_imm, i_exw, i_exr, i_a, i_b, i_jt);
        w = int'(mem_wdata);
        last_word = w;
        chk("we", mem_we, 1);
        chk("ready_in_write", in_ready, 0);
        chk("addr", mem_addr, exp_addr);
        chk("wdata", mem_wdata, exp_word);
        chk("dec_imm", dec(w, 3*P+2, 1), i_imm);
        chk("dec_exw", dec(w, 3*P+1, 1), i_exw);
        chk("dec_exr", dec(w, 3*P, 1), i_exr);
        chk("dec_a", dec(w, 2*P, P), i_a);
        chk("dec_b", dec(w, P, P), i_b);
        chk("dec_jt", dec(w, 0, P), i_jt);
        chk("count_in_write", count, exp_count);
        exp_count++;
        if (i_last != 0 || exp_addr == (1 << P) - 1) begin
            exp_done = 1;
            if (i_last == 0) exp_ovf = 1;
        end else begin
            exp_addr++;
        end
        sent++;
        step();
        chk("count", count, exp_count);
        chk("done", done, exp_done);
        chk("ovf", ovf, exp_ovf);
        chk("busy", busy, !exp_done);
        chk("we_after", mem_we, 0);
        chk("ready", in_ready, !exp_done);
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_count", count, 0);
        step();
        rst = 1'b0;
        // in_valid ignored in IDLE
        in_valid = 1'b1;
        step();
        step();
        chk("idle_ready", in_ready, 0);
        chk("idle_we", mem_we, 0);
        in_valid = 1'b0;

        // single-instruction program
        do_start();
        send(1, 0, 1, 5, 9, 13, 1, 0);
        chk("r33_word", last_word, 'h559D);
        chk("r33_count", count, 1);

        // two-instruction program
        do_start();
        send(0, 1, 0, 5, 9, 13, 0, 0);
        chk("r34_word0", last_word, 'h259D);
        send(0, 1, 0, 7, 11, 1, 1, 1);
        chk("r34_word1", last_word, 'h27B1);
        chk("r34_count", count, 2);
        chk("r34_ovf", ovf, 0);

        // overflow: 16 words without last
        do_start();
        for (int k = 0; k < 16; k++) send(k % 2, 0, 1, k, 15 - k, k, 0, 0);
        chk("r35_ovf", ovf, 1);
        chk("r35_count", count, 16);
        chk("r35_done", done, 1);
        chk("r35_ready", in_ready, 0);
        in_valid = 1'b1;
        repeat (3) begin
            step();
            chk("r35_no_we", mem_we, 0);
        end
        in_valid = 1'b0;
        chk("r35_count_held", count, 16);

        // asynchronous reset during WRITE
        do_start();
        send(0, 0, 0, 1, 2, 3, 0, 0);
        imm = 1'b1; a = 4'd6; b = 4'd7; jt = 4'd8; last = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("r36_we_before", mem_we, 1);
        #1 rst = 1'b1;
        #1;
        chk("r36_we_drop", mem_we, 0);
        chk("r36_busy", busy, 0);
        chk("r36_done", done, 0);
        chk("r36_count", count, 0);
        chk("r36_addr", mem_addr, 0);
        chk("r36_ready", in_ready, 0);
        step();
        rst = 1'b0;
        step();
        chk("r36_idle_we", mem_we, 0);
        do_start();
        send(0, 1, 1, 9, 8, 7, 1, 0);

        // start during WRITE with in_valid held high throughout
        do_start();
        send(1, 1, 1, 3, 3, 3, 0, 0);
        imm = 1'b0; exw = 1'b1; exr = 1'b0; a = 4'd10; b = 4'd11; jt = 4'd12; last = 1'b0;
        in_valid = 1'b1;
        step();
        start = 1'b1;
        #1;
        chk("r37_we", mem_we, 1);
        chk("r37_addr_w", mem_addr, 1);
        chk("r37_ready_w", in_ready, 0);
        step();
        chk("r37_ready_start", in_ready, 0);
        chk("r37_count", count, 0);
        chk("r37_addr", mem_addr, 0);
        chk("r37_busy", busy, 1);
        chk("r37_we_load", mem_we, 0);
        step();
        chk("r37_no_accept", mem_we, 0);
        chk("r37_ready_start2", in_ready, 0);
        start = 1'b0;
        #1;
        chk("r37_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("r37_we2", mem_we, 1);
        chk("r37_addr2", mem_addr, 0);
        chk("r37_wdata2", mem_wdata, pack_ref(0, 1, 0, 10, 11, 12));
        step();
        chk("r37_count2", count, 1);

        // randomized programs
        sent = 0;
        while (sent < 1000) begin
            int len;
            bit over;
            do_start();
            over = ($urandom_range(0, 7) == 0);
            len  = over ? 16 : int'($urandom_range(1, 16));
            for (int k = 0; k < len; k++) begin
                send(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     (!over && k == len - 1) ? 1 : 0, int'($urandom_range(0, 2)));
            end
            chk("rnd_done", done, 1);
            chk("rnd_count", count, len);
            chk("rnd_ovf", ovf, over);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
